// File: rtl/decimal_converter_seq.sv
// ============================================================================
// Module      : decimal_converter_seq
// Description : Sequential binary-to-BCD converter (double-dabble, one bit per
//               clock) with optional two's-complement input and saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decimal_converter_seq #(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_W-1:0]       bin_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [5*DIGITS-1:0]   pbcd_out,
    output logic                  sign_out,
    output logic                  overflow,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IN_W-1:0]   r_mag;
    logic [BW-1:0]     r_digits;
    logic [BW-1:0]     r_bcd;
    logic [CW-1:0]     r_cnt;
    logic              r_sign;
    logic              r_ovf;

    logic              w_is_neg;
    logic [IN_W-1:0]   w_mag_in;
    logic [BW-1:0]     w_adj;
    logic [BW-1:0]     w_digits_shifted;
    logic              w_carry;
    logic              w_last;
    logic              w_ovf_final;
    logic [BW-1:0]     w_bcd_final;

    // Negation is taken as IN_W-bit unsigned so the most-negative input maps to 2^(IN_W-1).
    assign w_is_neg = (SIGNED != 0) && bin_in[IN_W-1];
    assign w_mag_in = w_is_neg ? ((~bin_in) + IN_W'(1)) : bin_in;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_adj[4*gi +: 4] = (r_digits[4*gi +: 4] >= 4'd5) ?
                                      (r_digits[4*gi +: 4] + 4'd3) :
                                      r_digits[4*gi +: 4];
            assign pbcd_out[5*gi +: 5] = {1'b0, r_bcd[4*gi +: 4]};
        end
    endgenerate

    assign w_digits_shifted = {w_adj[BW-2:0], r_mag[IN_W-1]};
    assign w_carry          = w_adj[BW-1];
    assign w_last           = (r_cnt == CW'(IN_W - 1));
    assign w_ovf_final      = r_ovf | w_carry;
    assign w_bcd_final      = w_ovf_final ? {DIGITS{4'h9}} : w_digits_shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = SHIFT;
            SHIFT:   if (w_last) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag    <= '0;
            r_digits <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mag    <= w_mag_in;
                        r_sign   <= w_is_neg;
                        r_digits <= '0;
                        r_bcd    <= '0;
                        r_ovf    <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                SHIFT: begin
                    r_mag    <= r_mag << 1;
                    r_digits <= w_digits_shifted;
                    r_ovf    <= w_ovf_final;
                    r_cnt    <= r_cnt + CW'(1);
                    // Result register is loaded once, on the final shift, so it is frozen in DONE.
                    if (w_last) r_bcd <= w_bcd_final;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign bcd_out   = r_bcd;
    assign sign_out  = r_sign;
    assign overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_decimal_converter_seq.sv
// Testbench for decimal_converter_seq: three parameterisations (default, DIGITS=2,
// SIGNED=1) checked against a decimal-arithmetic reference model.
`default_nettype none

module tb_decimal_converter_seq;

    localparam int IN_W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid_d [3];
    logic [7:0]  bin_in_d   [3];
    logic        out_ready_d[3];
    logic        in_ready_a [3];
    logic        out_valid_a[3];
    logic        sign_a     [3];
    logic        ovf_a      [3];
    logic [11:0] bcd_a      [3];
    logic [14:0] pbcd_a     [3];

    logic [11:0] bcd0, bcd2;
    logic [7:0]  bcd1;
    logic [14:0] pbcd0, pbcd2;
    logic [9:0]  pbcd1;

    assign bcd_a[0]  = bcd0;
    assign bcd_a[1]  = {4'h0, bcd1};
    assign bcd_a[2]  = bcd2;
    assign pbcd_a[0] = pbcd0;
    assign pbcd_a[1] = {5'd0, pbcd1};
    assign pbcd_a[2] = pbcd2;

    decimal_converter_seq #(.IN_W(8), .DIGITS(3), .SIGNED(0)) u_dut_def (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_in_d[0]), .in_valid(in_valid_d[0]),
        .in_ready(in_ready_a[0]), .bcd_out(bcd0), .pbcd_out(pbcd0), .sign_out(sign_a[0]),
        .overflow(ovf_a[0]), .out_valid(out_valid_a[0]), .out_ready(out_ready_d[0]));

    decimal_converter_seq #(.IN_W(8), .DIGITS(2), .SIGNED(0)) u_dut_d2 (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_in_d[1]), .in_valid(in_valid_d[1]),
        .in_ready(in_ready_a[1]), .bcd_out(bcd1), .pbcd_out(pbcd1), .sign_out(sign_a[1]),
        .overflow(ovf_a[1]), .out_valid(out_valid_a[1]), .out_ready(out_ready_d[1]));

    decimal_converter_seq #(.IN_W(8), .DIGITS(3), .SIGNED(1)) u_dut_sgn (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_in_d[2]), .in_valid(in_valid_d[2]),
        .in_ready(in_ready_a[2]), .bcd_out(bcd2), .pbcd_out(pbcd2), .sign_out(sign_a[2]),
        .overflow(ovf_a[2]), .out_valid(out_valid_a[2]), .out_ready(out_ready_d[2]));

    // Reference: decimal value of the input, clipped to all-nines when it needs too many digits.
    function automatic void model(input int sel, input logic [7:0] v,
                                  output logic [11:0] e_bcd, output logic [14:0] e_pbcd,
                                  output logic e_sign, output logic e_ovf);
        int d, mag, lim, val;
        d      = (sel == 1) ? 2 : 3;
        e_sign = (sel == 2) && v[7];
        mag    = e_sign ? 256 - int'(v) : int'(v);
        lim    = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        e_ovf  = (mag >= lim);
        val    = e_ovf ? lim - 1 : mag;
        e_bcd  = '0;
        e_pbcd = '0;
        for (int i = 0; i < d; i++) begin
            e_bcd[4*i +: 4]  = 4'(val % 10);
            e_pbcd[5*i +: 5] = 5'(val % 10);
            val = val / 10;
        end
    endfunction

    // Accepts v on DUT sel and waits for out_valid; lat = edges from accept to out_valid, -1 on timeout.
    task automatic run_conv(input int sel, input logic [7:0] v, output int lat);
        bit seen;
        @(negedge clk);
        bin_in_d[sel]    = v;
        in_valid_d[sel]  = 1'b1;
        out_ready_d[sel] = 1'b0;
        @(posedge clk);
        #1;
        in_valid_d[sel] = 1'b0;
        lat  = -1;
        seen = 1'b0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (out_valid_a[sel]) begin
                lat  = n;
                seen = 1'b1;
            end
        end
    endtask

    task automatic release_result(input int sel);
        @(negedge clk);
        out_ready_d[sel] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_d[sel] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            in_valid_d[s]  = 1'b0;
            bin_in_d[s]    = 8'h00;
            out_ready_d[s] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({bcd_a[s], pbcd_a[s], sign_a[s], ovf_a[s], out_valid_a[s]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got bcd=%h pbcd=%h sign=%b ovf=%b ov=%b, want all 0",
                         s, bcd_a[s], pbcd_a[s], sign_a[s], ovf_a[s], out_valid_a[s]);
            end
            checks++;
            if (in_ready_a[s] !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready dut%0d: got %b want 1", s, in_ready_a[s]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_defaults();
        int lat;
        run_conv(0, 8'd255, lat);
        checks++;
        if (lat !== IN_W) begin
            errors++;
            $display("FAIL def255_latency: got %0d want %0d", lat, IN_W);
        end
        checks++;
        if (bcd_a[0] !== 12'h255 || pbcd_a[0] !== {5'd2, 5'd5, 5'd5}) begin
            errors++;
            $display("FAIL def255_value: got bcd=%h pbcd=%h want 255/%h",
                     bcd_a[0], pbcd_a[0], {5'd2, 5'd5, 5'd5});
        end
        checks++;
        if (ovf_a[0] !== 1'b0 || sign_a[0] !== 1'b0 || in_ready_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL def255_flags: got ovf=%b sign=%b in_ready=%b want 0 0 0",
                     ovf_a[0], sign_a[0], in_ready_a[0]);
        end
        release_result(0);
        checks++;
        if (in_ready_a[0] !== 1'b1 || out_valid_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL def255_release: got in_ready=%b out_valid=%b want 1 0",
                     in_ready_a[0], out_valid_a[0]);
        end
    endtask

    task automatic test_digits2();
        int lat;
        run_conv(1, 8'd99, lat);
        checks++;
        if (bcd_a[1] !== 12'h099 || ovf_a[1] !== 1'b0 || lat !== IN_W) begin
            errors++;
            $display("FAIL d2_99: got bcd=%h ovf=%b lat=%0d want 099 0 %0d", bcd_a[1], ovf_a[1], lat, IN_W);
        end
        release_result(1);
        run_conv(1, 8'd100, lat);
        checks++;
        if (bcd_a[1] !== 12'h099 || pbcd_a[1] !== 15'h0129 || ovf_a[1] !== 1'b1) begin
            errors++;
            $display("FAIL d2_100_sat: got bcd=%h pbcd=%h ovf=%b want 099 0129 1",
                     bcd_a[1], pbcd_a[1], ovf_a[1]);
        end
        release_result(1);
    endtask

    task automatic test_signed();
        logic [7:0]  vals [3] = '{8'h80, 8'hFF, 8'h00};
        logic [11:0] ebcd [3] = '{12'h128, 12'h001, 12'h000};
        logic        esgn [3] = '{1'b1, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_conv(2, vals[i], lat);
            checks++;
            if (bcd_a[2] !== ebcd[i] || sign_a[2] !== esgn[i] || ovf_a[2] !== 1'b0) begin
                errors++;
                $display("FAIL signed_%h: got bcd=%h sign=%b ovf=%b want %h %b 0",
                         vals[i], bcd_a[2], sign_a[2], ovf_a[2], ebcd[i], esgn[i]);
            end
            release_result(2);
        end
    endtask

    task automatic test_random();
        logic [7:0]  corner [10] = '{8'd0, 8'd1, 8'd9, 8'd10, 8'd99, 8'd100, 8'd127, 8'd128, 8'd254, 8'd255};
        logic [7:0]  v;
        logic [11:0] e_bcd;
        logic [14:0] e_pbcd;
        logic        e_sign, e_ovf;
        int lat;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 22; i++) begin
                v = (i < 10) ? corner[i] : 8'($urandom_range(0, 255));
                model(s, v, e_bcd, e_pbcd, e_sign, e_ovf);
                run_conv(s, v, lat);
                checks++;
                if (lat !== IN_W || bcd_a[s] !== e_bcd || pbcd_a[s] !== e_pbcd ||
                    sign_a[s] !== e_sign || ovf_a[s] !== e_ovf) begin
                    errors++;
                    $display("FAIL rand dut%0d in=%h: got lat=%0d bcd=%h pbcd=%h sign=%b ovf=%b want lat=%0d bcd=%h pbcd=%h sign=%b ovf=%b",
                             s, v, lat, bcd_a[s], pbcd_a[s], sign_a[s], ovf_a[s],
                             IN_W, e_bcd, e_pbcd, e_sign, e_ovf);
                end
                release_result(s);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        run_conv(0, 8'd123, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid_d[0] = (i % 2 == 0);
            bin_in_d[0]   = 8'd7 + 8'(i);
            @(posedge clk);
            #1;
            checks++;
            if (out_valid_a[0] !== 1'b1 || in_ready_a[0] !== 1'b0 || bcd_a[0] !== 12'h123 ||
                pbcd_a[0] !== {5'd1, 5'd2, 5'd3} || ovf_a[0] !== 1'b0 || sign_a[0] !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: got ov=%b ir=%b bcd=%h pbcd=%h want 1 0 123 %h",
                         i, out_valid_a[0], in_ready_a[0], bcd_a[0], pbcd_a[0], {5'd1, 5'd2, 5'd3});
            end
        end
        @(negedge clk);
        in_valid_d[0]  = 1'b0;
        out_ready_d[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_d[0] = 1'b0;
        checks++;
        if (in_ready_a[0] !== 1'b1 || out_valid_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got in_ready=%b out_valid=%b want 1 0", in_ready_a[0], out_valid_a[0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL hold_no_buffered_accept: got in_ready=%b want 1", in_ready_a[0]);
        end
    endtask

    task automatic test_reset_mid();
        int  lat;
        bit  saw_valid;
        @(negedge clk);
        bin_in_d[0]   = 8'd200;
        in_valid_d[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_d[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready_a[0] !== 1'b1 || out_valid_a[0] !== 1'b0 || bcd_a[0] !== 12'h000 ||
            pbcd_a[0] !== 15'h0000 || sign_a[0] !== 1'b0 || ovf_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: got ir=%b ov=%b bcd=%h pbcd=%h sign=%b ovf=%b want 1 0 0 0 0 0",
                     in_ready_a[0], out_valid_a[0], bcd_a[0], pbcd_a[0], sign_a[0], ovf_a[0]);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid_a[0]) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_valid: got out_valid pulse=%b want 0", saw_valid);
        end
        run_conv(0, 8'd42, lat);
        checks++;
        if (bcd_a[0] !== 12'h042 || lat !== IN_W) begin
            errors++;
            $display("FAIL midreset_then_42: got bcd=%h lat=%0d want 042 %0d", bcd_a[0], lat, IN_W);
        end
        release_result(0);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  vals [4] = '{8'd0, 8'd9, 8'd10, 8'd200};
        logic [11:0] ebcd [4] = '{12'h000, 12'h009, 12'h010, 12'h200};
        int  prev_acc, acc, w;
        bit  seen;
        prev_acc = -1;
        out_ready_d[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = 0;
            @(negedge clk);
            while (!in_ready_a[0] && w < 40) begin
                @(negedge clk);
                w++;
            end
            checks++;
            if (w >= 40) begin
                errors++;
                $display("FAIL b2b_ready_timeout item%0d: got in_ready=%b want 1", i, in_ready_a[0]);
            end
            bin_in_d[0]   = vals[i];
            in_valid_d[0] = 1'b1;
            @(posedge clk);
            #1;
            acc = cyc;
            // IN_W shift edges, one DONE->IDLE edge, then the next accepting edge.
            if (prev_acc >= 0) begin
                checks++;
                if (acc - prev_acc !== IN_W + 2) begin
                    errors++;
                    $display("FAIL b2b_spacing item%0d: got %0d edges want %0d", i, acc - prev_acc, IN_W + 2);
                end
            end
            prev_acc = acc;
            seen = 1'b0;
            for (int n = 0; n < 40 && !seen; n++) begin
                @(posedge clk);
                #1;
                if (out_valid_a[0]) begin
                    seen = 1'b1;
                    checks++;
                    if (bcd_a[0] !== ebcd[i]) begin
                        errors++;
                        $display("FAIL b2b_value item%0d: got %h want %h", i, bcd_a[0], ebcd[i]);
                    end
                end
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL b2b_valid_timeout item%0d: got no out_valid", i);
            end
        end
        @(negedge clk);
        in_valid_d[0]  = 1'b0;
        out_ready_d[0] = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_digits2();
        test_signed();
        test_random();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout want completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
